jt12_slot_ring_wr: RTL and testbench

Circulating per-slot parameter store with a deferred write port for the FM operator pipeline. Holds one `width`-bit value for each of `slots` time slots in a recirculating shift ring advanced by `clk_en`, presenting the value of the current slot at `dout`. Sits between the register-write decoder and the operator/envelope stages. A register write is latched, held pending, and committed into the ring only when the ring passes the target slot. The block also generates the slot counter and sync pulse that downstream per-slot shift stages align to.

---
 rtl/jt12_slot_ring_wr.sv | 100 ++++++++++
 tb/tb_jt12_slot_ring_wr.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt12_slot_ring_wr.sv
// jt12_slot_ring_wr: recirculating per-slot value ring with a deferred write.
// In: clk, rst, clk_en, wr_req/wr_slot/wr_data. Out: wr_busy/done/err, slot, sync, dout.
module jt12_slot_ring_wr #(
  parameter int   width  = 8,
  parameter int   slots  = 24,
  parameter logic rstval = 1'b0,
  localparam int  SW     = $clog2(slots)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             wr_req,
  input  logic [SW-1:0]    wr_slot,
  input  logic [width-1:0] wr_data,
  output logic             wr_busy,
  output logic             wr_done,
  output logic             wr_err,
  output logic [SW-1:0]    slot,
  output logic             sync,
  output logic [width-1:0] dout
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  localparam logic [SW:0]      SLOTS_W = (SW+1)'(slots);
  localparam logic [SW-1:0]    LAST    = SW'(slots - 1);
  localparam logic [width-1:0] RST_W   = {width{rstval}};

  state_t state, state_nx;

  logic [width-1:0] ring [slots];
  logic [SW-1:0]    tgt;
  logic [width-1:0] wdat;
  logic             slot_ok;
  logic             accept;
  logic             reject;
  logic             commit;

  // Extra top bit keeps the bound check valid when slots is a power of two.
  assign slot_ok = {1'b0, wr_slot} < SLOTS_W;
  assign dout    = ring[slots-1];
  assign sync    = slot == '0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // accept needs IDLE and commit needs PEND, so they never coincide.
  always_comb begin
    state_nx = state;
    unique case (1'b1)
      accept:  state_nx = PEND;
      commit:  state_nx = IDLE;
      default: state_nx = state;
    endcase
  end

  always_comb begin
    wr_busy = state == PEND;
    accept  = wr_req && !wr_busy && slot_ok;
    reject  = wr_req && !wr_busy && !slot_ok;
    commit  = wr_busy && clk_en && (slot == tgt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tgt     <= '0;
      wdat    <= '0;
      wr_done <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      wr_done <= commit;
      wr_err  <= reject;
      if (accept) begin
        tgt  <= wr_slot;
        wdat <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         slot <= '0;
    else if (clk_en) slot <= (slot == LAST) ? '0 : slot + 1'b1;
  end

  // The head value re-enters at stage 0, so a commit replaces it there.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < slots; i++) ring[i] <= RST_W;
    end else if (clk_en) begin
      ring[0] <= commit ? wdat : dout;
      for (int i = 1; i < slots; i++) ring[i] <= ring[i-1];
    end
  end

endmodule

// File: tb/tb_jt12_slot_ring_wr.sv
// tb_jt12_slot_ring_wr: self-checking bench for jt12_slot_ring_wr.
// Array-per-slot reference model, directed scenarios plus random stimulus.
module tb_jt12_slot_ring_wr;

  localparam int SLOTS = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b0;
  logic       wr_req = 1'b0;
  logic [4:0] wr_slot = '0;
  logic [7:0] wr_data = '0;
  logic       wr_busy, wr_done, wr_err, sync;
  logic [4:0] slot;
  logic [7:0] dout;

  int n_chk = 0;
  int n_fail = 0;

  jt12_slot_ring_wr dut (
    .clk     (clk),
    .rst     (rst),
    .clk_en  (clk_en),
    .wr_req  (wr_req),
    .wr_slot (wr_slot),
    .wr_data (wr_data),
    .wr_busy (wr_busy),
    .wr_done (wr_done),
    .wr_err  (wr_err),
    .slot    (slot),
    .sync    (sync),
    .dout    (dout)
  );

  always #5 clk = ~clk;

  // Reference: one memory cell per slot plus a pending-write record.
  logic [7:0] m_mem [SLOTS];
  int         m_slot = 0;
  int         m_tgt = 0;
  logic [7:0] m_dat = '0;
  bit         m_busy = 0;
  bit         m_done = 0;
  bit         m_err = 0;

  always @(posedge clk) begin : model
    bit ob, cm;
    if (rst) begin
      foreach (m_mem[i]) m_mem[i] = 8'h00;
      m_slot = 0;
      m_busy = 0;
      m_done = 0;
      m_err  = 0;
    end else begin
      ob = m_busy;
      cm = ob && clk_en && (m_slot == m_tgt);
      m_done = cm;
      m_err  = 0;
      if (cm) begin
        m_busy = 0;
        m_mem[m_tgt] = m_dat;
      end
      if (!ob && wr_req) begin
        if (int'(wr_slot) < SLOTS) begin
          m_busy = 1;
          m_tgt  = int'(wr_slot);
          m_dat  = wr_data;
        end else begin
          m_err = 1;
        end
      end
      if (clk_en) m_slot = (m_slot + 1) % SLOTS;
    end
  end

  function automatic logic [16:0] mvec();
    return {5'(m_slot), m_slot == 0, m_busy, m_done, m_err, m_mem[m_slot]};
  endfunction

  function automatic logic [16:0] dvec();
    return {slot, sync, wr_busy, wr_done, wr_err, dout};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_slot(input int s, output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (int'(slot) == s) begin
        ok = 1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    bit seen;
    rst = 1; clk_en = 0; wr_req = 0;
    tick(); tick();
    n_chk++;
    if (dvec() !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_state got=%h exp=%h", dvec(), {5'd0, 4'b1000, 8'h00});
    end
    rst = 0; clk_en = 1;
    tick(); tick(); tick();
    wr_req = 1; wr_slot = 5'd10; wr_data = 8'(32'h5A);
    tick();
    wr_req = 0;
    n_chk++;
    if (wr_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_accept busy=%b exp=1", wr_busy);
    end
    tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    n_chk++;
    if ({slot, sync, wr_busy} !== {5'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid slot=%0d sync=%b busy=%b", slot, sync, wr_busy);
    end
    seen = 0;
    for (int i = 0; i < SLOTS + 2; i++) begin
      n_chk++;
      if (dout !== 8'h00 || wr_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_rev slot=%0d dout=%h busy=%b exp 00/0", slot, dout, wr_busy);
      end
      n_chk++;
      if (dvec() !== mvec()) begin
        n_fail++;
        $display("FAIL reset_model got=%h exp=%h", dvec(), mvec());
      end
      tick();
      if (wr_done) seen = 1;
    end
    n_chk++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_done seen=%b exp=0", seen);
    end
  endtask

  task automatic test_basic_write();
    bit ok;
    logic [7:0] exp_d;
    clk_en = 1;
    goto_slot(0, ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL basic_goto timeout slot=%0d", slot);
    end
    wr_req = 1; wr_slot = 5'd5; wr_data = 8'hA5;
    tick();
    wr_req = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_chk++;
      if (k < 5 && {wr_busy, wr_done} !== 2'b10) begin
        n_fail++;
        $display("FAIL basic_pend k=%0d busy/done=%b%b exp=10", k, wr_busy, wr_done);
      end else if (k == 5 && {wr_busy, wr_done, slot} !== {2'b01, 5'd6}) begin
        n_fail++;
        $display("FAIL basic_commit busy/done=%b%b slot=%0d exp 01/6", wr_busy, wr_done, slot);
      end
    end
    tick();
    n_chk++;
    if (wr_done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_pulse done=%b exp=0", wr_done);
    end
    for (int i = 0; i < SLOTS; i++) begin
      exp_d = (slot == 5'd5) ? 8'hA5 : 8'h00;
      n_chk++;
      if (dout !== exp_d) begin
        n_fail++;
        $display("FAIL basic_read slot=%0d dout=%h exp=%h", slot, dout, exp_d);
      end
      tick();
    end
  endtask

  task automatic test_full_rev();
    bit ok;
    int cnt;
    logic [7:0] d;
    d = 8'($urandom);
    clk_en = 1;
    goto_slot(7, ok);
    wr_req = 1; wr_slot = 5'd7; wr_data = d;
    tick();
    wr_req = 0;
    cnt = 0;
    while (wr_busy && cnt < 40) begin
      n_chk++;
      if (dvec() !== mvec()) begin
        n_fail++;
        $display("FAIL fullrev_model got=%h exp=%h", dvec(), mvec());
      end
      tick();
      cnt++;
    end
    n_chk++;
    if (cnt !== 24 || wr_done !== 1'b1) begin
      n_fail++;
      $display("FAIL fullrev_len edges=%0d done=%b exp 24/1", cnt, wr_done);
    end
    goto_slot(7, ok);
    n_chk++;
    if (!ok || dout !== d) begin
      n_fail++;
      $display("FAIL fullrev_data dout=%h exp=%h", dout, d);
    end
  endtask

  task automatic test_gated();
    bit seen, en;
    int ps;
    logic [7:0] pd, d;
    d = 8'($urandom);
    clk_en = 0;
    wr_req = 1; wr_slot = 5'd23; wr_data = d;
    tick();
    wr_req = 0;
    n_chk++;
    if (wr_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL gated_accept busy=%b exp=1", wr_busy);
    end
    seen = 0;
    for (int c = 0; c < SLOTS * 12; c++) begin
      en = (c % 6) == 5;
      clk_en = en;
      ps = int'(slot);
      pd = dout;
      tick();
      n_chk++;
      if (dvec() !== mvec()) begin
        n_fail++;
        $display("FAIL gated_model got=%h exp=%h", dvec(), mvec());
      end
      n_chk++;
      if (!en && {int'(slot), dout} !== {ps, pd}) begin
        n_fail++;
        $display("FAIL gated_hold slot=%0d dout=%h exp %0d/%h", slot, dout, ps, pd);
      end else if (en && ps == 23 && !seen) begin
        seen = 1;
        if ({slot, sync, wr_busy, wr_done} !== {5'd0, 3'b101}) begin
          n_fail++;
          $display("FAIL gated_commit slot=%0d sync=%b busy=%b done=%b", slot, sync, wr_busy, wr_done);
        end
      end else if (en && int'(slot) != (ps + 1) % SLOTS) begin
        n_fail++;
        $display("FAIL gated_step slot=%0d exp=%0d", slot, (ps + 1) % SLOTS);
      end
    end
    clk_en = 0;
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL gated_seen commit=%b exp=1", seen);
    end
  endtask

  task automatic test_collision_error();
    bit ok;
    int t;
    logic [7:0] d1;
    clk_en = 1;
    t = (int'(slot) + 10) % SLOTS;
    d1 = 8'($urandom);
    wr_req = 1; wr_slot = 5'(t); wr_data = d1;
    tick();
    wr_req = 0;
    tick();
    wr_req = 1; wr_slot = 5'($urandom_range(0, 23)); wr_data = ~d1;
    tick();
    wr_req = 0;
    n_chk++;
    if ({wr_err, wr_busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL coll_ignored err/busy=%b%b exp=01", wr_err, wr_busy);
    end
    for (int i = 0; i < 40; i++) begin
      if (wr_done) break;
      tick();
    end
    n_chk++;
    if (wr_done !== 1'b1) begin
      n_fail++;
      $display("FAIL coll_done done=%b exp=1", wr_done);
    end
    goto_slot(t, ok);
    n_chk++;
    if (dout !== d1) begin
      n_fail++;
      $display("FAIL coll_data dout=%h exp=%h", dout, d1);
    end
    wr_req = 1; wr_slot = 5'($urandom_range(24, 31)); wr_data = 8'($urandom);
    tick();
    wr_req = 0;
    n_chk++;
    if ({wr_err, wr_busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL err_pulse err/busy=%b%b exp=10", wr_err, wr_busy);
    end
    tick();
    n_chk++;
    if (wr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_width err=%b exp=0", wr_err);
    end
    for (int i = 0; i < SLOTS; i++) begin
      n_chk++;
      if (dvec() !== mvec()) begin
        n_fail++;
        $display("FAIL err_ring got=%h exp=%h", dvec(), mvec());
      end
      tick();
    end
    goto_slot(t, ok);
    n_chk++;
    if (dout !== d1) begin
      n_fail++;
      $display("FAIL err_keep dout=%h exp=%h", dout, d1);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clk_en = 1;
    wr_req = 1; wr_slot = 5'd3; wr_data = 8'h11;
    tick();
    wr_req = 0;
    for (int i = 0; i < 40; i++) begin
      if (wr_done) break;
      tick();
    end
    n_chk++;
    if (wr_done !== 1'b1 || wr_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first done=%b busy=%b exp 1/0", wr_done, wr_busy);
    end
    wr_req = 1; wr_slot = 5'd3; wr_data = 8'h22;
    tick();
    wr_req = 0;
    n_chk++;
    if (wr_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept busy=%b exp=1", wr_busy);
    end
    for (int i = 0; i < 40; i++) begin
      if (wr_done) break;
      tick();
    end
    n_chk++;
    if (wr_done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second done=%b exp=1", wr_done);
    end
    goto_slot(3, ok);
    n_chk++;
    if (dout !== 8'h22) begin
      n_fail++;
      $display("FAIL b2b_data dout=%h exp=22", dout);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst     = $urandom_range(0, 149) == 0;
      clk_en  = $urandom_range(0, 2) != 0;
      wr_req  = $urandom_range(0, 3) == 0;
      wr_slot = 5'($urandom_range(0, 31));
      wr_data = 8'($urandom);
      tick();
      n_chk++;
      if (dvec() !== mvec()) begin
        n_fail++;
        $display("FAIL random_cyc%0d got=%h exp=%h", i, dvec(), mvec());
      end
    end
    rst = 0;
    wr_req = 0;
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_full_rev();
    test_gated();
    test_collision_error();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
